// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB encodings, FSM state type and byte-lane helpers for ahb_sram_slave.
// The error states exist only when AHB_SRAM_SLAVE_ERR_EN is defined.
package AhbGlobalPackage;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

`ifdef AHB_SRAM_SLAVE_ERR_EN
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT} state_t;
`endif

  // Little-endian lane mask; misaligned halves/words collapse onto their aligned lanes.
  function automatic logic [3:0] laneEnable(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      HSIZE_BYTE: laneEnable = 4'b0001 << lane;
      HSIZE_HALF: laneEnable = lane[1] ? 4'b1100 : 4'b0011;
      default:    laneEnable = 4'b1111;
    endcase
  endfunction

  function automatic logic isMisaligned(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      HSIZE_BYTE: isMisaligned = 1'b0;
      HSIZE_HALF: isMisaligned = lane[0];
      HSIZE_WORD: isMisaligned = |lane;
      default:    isMisaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_byte_mem.sv
// Single-port word storage with per-byte write enables, clocked write and asynchronous read.
module ahb_sram_byte_mem #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic [IDX_W-1:0] i_addr,
  input  logic [3:0]       i_we,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with configurable wait states and zero-bubble pipelining.
// Define AHB_SRAM_SLAVE_ERR_EN to flag out-of-range and misaligned transfers with an ERROR response.
module ahb_sram_slave
  import AhbGlobalPackage::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hselx,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hmastlock,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic                  hreadyout,
  output logic [1:0]            hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t           r_state;
  state_t           w_stateNext;
  logic [3:0]       r_waitCnt;
  logic             r_dpValid;
  logic             r_dpWrite;
  logic [IDX_W-1:0] r_dpIndex;
  logic [3:0]       r_dpLanes;
  logic             w_accept;
  logic             w_error;
  logic             w_complete;
  logic [3:0]       w_memWe;
  logic [31:0]      w_memRdata;
  logic             w_unused;

`ifdef AHB_SRAM_SLAVE_ERR_EN
  assign w_error  = (|haddr[ADDR_WIDTH-1:IDX_W+2]) || isMisaligned(hsize, haddr[1:0]);
  assign w_unused = ^{hburst, hprot, hmastlock};
`else
  assign w_error  = 1'b0;
  assign w_unused = ^{haddr[ADDR_WIDTH-1:IDX_W+2], hburst, hprot, hmastlock};
`endif

  // A data phase completes in any ST_IDLE cycle that still holds a valid transfer.
  assign w_complete = r_dpValid && (r_state == ST_IDLE);

  always_comb begin
    hreadyout   = 1'b1;
    hresp       = HRESP_OKAY;
    w_stateNext = r_state;
    case (r_state)
      ST_WAIT: hreadyout = 1'b0;
`ifdef AHB_SRAM_SLAVE_ERR_EN
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      ST_ERR2: hresp = HRESP_ERROR;
`endif
      default: ;
    endcase

    w_accept = hselx && hready && htrans[1] && hreadyout;

    case (r_state)
      ST_WAIT: if (r_waitCnt == 4'd0) w_stateNext = ST_IDLE;
`ifdef AHB_SRAM_SLAVE_ERR_EN
      ST_ERR1: w_stateNext = ST_ERR2;
`endif
      default: begin
        w_stateNext = ST_IDLE;
        if (w_accept && (WAIT_STATES > 0)) w_stateNext = ST_WAIT;
`ifdef AHB_SRAM_SLAVE_ERR_EN
        if (w_accept && w_error) w_stateNext = ST_ERR1;
`endif
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state   <= ST_IDLE;
      r_waitCnt <= 4'd0;
      r_dpValid <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (w_accept) begin
        r_dpValid <= !w_error;
        r_waitCnt <= WAIT_INIT;
      end else begin
        if (w_complete) r_dpValid <= 1'b0;
        if ((r_state == ST_WAIT) && (r_waitCnt != 4'd0)) r_waitCnt <= r_waitCnt - 4'd1;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (w_accept) begin
      r_dpWrite <= hwrite;
      r_dpIndex <= haddr[IDX_W+1:2];
      r_dpLanes <= laneEnable(hsize, haddr[1:0]);
    end
  end

  // A reset landing on the completing edge must not commit the pending write.
  assign w_memWe = (w_complete && r_dpWrite && !hreset) ? r_dpLanes : 4'b0000;
  assign hrdata  = (w_complete && !r_dpWrite) ? w_memRdata : '0;

  ahb_sram_byte_mem #(
    .DEPTH (MEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .i_clk   (hclk),
    .i_addr  (r_dpIndex),
    .i_we    (w_memWe),
    .i_wdata (hwdata),
    .o_rdata (w_memRdata)
  );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed self-checking bench for ahb_sram_slave: three instances with WAIT_STATES 0, 3 and 5.
// Define AHB_SRAM_SLAVE_ERR_EN to exercise the error responses instead of truncation/aliasing.
module tb_ahb_sram_slave;

  logic        hclk;
  logic        hreset;
  logic [2:0]  hselx;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  wire  [2:0]  hreadyout;
  wire  [1:0]  hresp  [3];
  wire  [31:0] hrdata [3];

  int total = 0;
  int bad   = 0;

  // Instance 0 has no wait states, instance 1 has three, instance 2 has five.
  for (genvar g = 0; g < 3; g++) begin : gDut
    ahb_sram_slave #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .MEM_DEPTH   (1024),
      .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 3 : 5))
    ) dut (
      .hclk      (hclk),
      .hreset    (hreset),
      .hselx     (hselx[g]),
      .haddr     (haddr),
      .htrans    (htrans),
      .hwrite    (hwrite),
      .hsize     (hsize),
      .hburst    (hburst),
      .hprot     (hprot),
      .hmastlock (hmastlock),
      .hready    (hreadyout[g]),
      .hwdata    (hwdata),
      .hreadyout (hreadyout[g]),
      .hresp     (hresp[g]),
      .hrdata    (hrdata[g])
    );
  end

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    @(negedge hclk);
  endtask

  task automatic idleBus();
    hselx     = 3'b000;
    htrans    = 2'b00;
    hwrite    = 1'b0;
    haddr     = 32'h0;
    hsize     = 3'b010;
    hburst    = 3'b000;
    hprot     = 4'b0011;
    hmastlock = 1'b0;
  endtask

  task automatic addrPhase(input int d, input logic [31:0] addr, input logic wr, input logic [2:0] size);
    hselx     = 3'b000;
    hselx[d]  = 1'b1;
    htrans    = 2'b10;
    haddr     = addr;
    hwrite    = wr;
    hsize     = size;
  endtask

  // One isolated transfer; returns data/response seen in the completing cycle and the stall count.
  task automatic applyStimulus(input int d, input logic [31:0] addr, input logic wr,
                               input logic [2:0] size, input logic [31:0] wdata,
                               output logic [31:0] rdata, output int lowCnt, output logic [1:0] resp);
    addrPhase(d, addr, wr, size);
    tick();
    idleBus();
    hwdata = wdata;
    lowCnt = 0;
    while (hreadyout[d] === 1'b0 && lowCnt < 40) begin
      lowCnt++;
      tick();
    end
    rdata = hrdata[d];
    resp  = hresp[d];
    tick();
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      total++;
      if (hreadyout[d] !== 1'b1) begin
        bad++;
        $display("[TB] FAIL reset_hreadyout dut%0d: got %b want 1", d, hreadyout[d]);
      end
      total++;
      if (hresp[d] !== 2'b00) begin
        bad++;
        $display("[TB] FAIL reset_hresp dut%0d: got %b want 00", d, hresp[d]);
      end
      total++;
      if (hrdata[d] !== 32'h0) begin
        bad++;
        $display("[TB] FAIL reset_hrdata dut%0d: got %h want 0", d, hrdata[d]);
      end
    end
    hreset = 1'b0;
    tick();
  endtask

  task automatic test_single_rw();
    logic [31:0] rd;
    int          lc;
    logic [1:0]  rs;
    applyStimulus(0, 32'h10, 1'b1, 3'b010, 32'hDEADBEEF, rd, lc, rs);
    total++;
    if (lc !== 0) begin
      bad++;
      $display("[TB] FAIL single_write_stall: got %0d want 0", lc);
    end
    applyStimulus(0, 32'h10, 1'b0, 3'b010, 32'h0, rd, lc, rs);
    total++;
    if (rd !== 32'hDEADBEEF) begin
      bad++;
      $display("[TB] FAIL single_read_data: got %h want deadbeef", rd);
    end
    total++;
    if (rs !== 2'b00 || lc !== 0) begin
      bad++;
      $display("[TB] FAIL single_read_resp: got resp=%b stall=%0d want resp=00 stall=0", rs, lc);
    end
    total++;
    if (hrdata[0] !== 32'h0) begin
      bad++;
      $display("[TB] FAIL rdata_outside_phase: got %h want 0", hrdata[0]);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    int          lc;
    logic [1:0]  rs;
    applyStimulus(0, 32'h10, 1'b1, 3'b010, 32'h11223344, rd, lc, rs);
    applyStimulus(0, 32'h13, 1'b1, 3'b000, 32'hAA5566FF, rd, lc, rs);
    applyStimulus(0, 32'h10, 1'b0, 3'b010, 32'h0, rd, lc, rs);
    total++;
    if (rd !== 32'hAA223344) begin
      bad++;
      $display("[TB] FAIL byte_lane3: got %h want aa223344", rd);
    end
    applyStimulus(0, 32'h10, 1'b1, 3'b001, 32'h9999BEEF, rd, lc, rs);
    applyStimulus(0, 32'h11, 1'b1, 3'b000, 32'h00007700, rd, lc, rs);
    applyStimulus(0, 32'h10, 1'b0, 3'b010, 32'h0, rd, lc, rs);
    total++;
    if (rd !== 32'hAA2277EF) begin
      bad++;
      $display("[TB] FAIL half_and_byte_lanes: got %h want aa2277ef", rd);
    end
  endtask

  task automatic test_back_to_back();
    addrPhase(0, 32'h40, 1'b1, 3'b010);
    tick();
    hwdata = 32'h00000005;
    addrPhase(0, 32'h40, 1'b0, 3'b010);
    total++;
    if (hreadyout[0] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL b2b_write_ready: got %b want 1", hreadyout[0]);
    end
    tick();
    idleBus();
    total++;
    if (hrdata[0] !== 32'h5 || hreadyout[0] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL b2b_read: got data=%h ready=%b want data=00000005 ready=1", hrdata[0], hreadyout[0]);
    end
    tick();
  endtask

  task automatic test_idle_busy();
    logic [31:0] rd;
    int          lc;
    logic [1:0]  rs;
    hwdata = 32'hBAD0BAD0;
    addrPhase(0, 32'h40, 1'b1, 3'b010);
    htrans = 2'b01;
    tick();
    total++;
    if (hreadyout[0] !== 1'b1 || hresp[0] !== 2'b00 || hrdata[0] !== 32'h0) begin
      bad++;
      $display("[TB] FAIL busy_no_phase: got ready=%b resp=%b data=%h want 1/00/0", hreadyout[0], hresp[0], hrdata[0]);
    end
    htrans = 2'b10;
    hselx  = 3'b000;
    tick();
    htrans   = 2'b00;
    hselx[0] = 1'b1;
    tick();
    total++;
    if (hreadyout[0] !== 1'b1 || hrdata[0] !== 32'h0) begin
      bad++;
      $display("[TB] FAIL idle_no_phase: got ready=%b data=%h want 1/0", hreadyout[0], hrdata[0]);
    end
    idleBus();
    tick();
    applyStimulus(0, 32'h40, 1'b0, 3'b010, 32'h0, rd, lc, rs);
    total++;
    if (rd !== 32'h5) begin
      bad++;
      $display("[TB] FAIL unselected_no_write: got %h want 00000005", rd);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    int          lc;
    logic [1:0]  rs;
    logic        leak;
    applyStimulus(1, 32'h20, 1'b1, 3'b010, 32'hCAFEF00D, rd, lc, rs);
    total++;
    if (lc !== 3) begin
      bad++;
      $display("[TB] FAIL wait_write_stall: got %0d want 3", lc);
    end
    // Second address phase stays on the bus for the whole first read.
    addrPhase(1, 32'h20, 1'b0, 3'b010);
    tick();
    lc   = 0;
    leak = 1'b0;
    while (hreadyout[1] === 1'b0 && lc < 40) begin
      if (hrdata[1] !== 32'h0) leak = 1'b1;
      lc++;
      tick();
    end
    total++;
    if (lc !== 3 || leak) begin
      bad++;
      $display("[TB] FAIL wait_read_stall: got %0d leak=%b want 3 leak=0", lc, leak);
    end
    total++;
    if (hrdata[1] !== 32'hCAFEF00D || hresp[1] !== 2'b00) begin
      bad++;
      $display("[TB] FAIL wait_read_data: got %h resp=%b want cafef00d resp=00", hrdata[1], hresp[1]);
    end
    tick();
    idleBus();
    lc = 0;
    while (hreadyout[1] === 1'b0 && lc < 40) begin
      lc++;
      tick();
    end
    total++;
    if (lc !== 3 || hrdata[1] !== 32'hCAFEF00D) begin
      bad++;
      $display("[TB] FAIL held_phase_read: got stall=%0d data=%h want 3/cafef00d", lc, hrdata[1]);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd;
    int          lc;
    logic [1:0]  rs;
    applyStimulus(2, 32'h30, 1'b1, 3'b010, 32'h01020304, rd, lc, rs);
    total++;
    if (lc !== 5) begin
      bad++;
      $display("[TB] FAIL wait5_stall: got %0d want 5", lc);
    end
    addrPhase(2, 32'h30, 1'b1, 3'b010);
    tick();
    idleBus();
    hwdata = 32'hFFFFFFFF;
    tick();
    tick();
    hreset = 1'b1;
    tick();
    total++;
    if (hreadyout[2] !== 1'b1 || hresp[2] !== 2'b00 || hrdata[2] !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_mid_wait: got ready=%b resp=%b data=%h want 1/00/0", hreadyout[2], hresp[2], hrdata[2]);
    end
    hreset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    applyStimulus(2, 32'h30, 1'b0, 3'b010, 32'h0, rd, lc, rs);
    total++;
    if (rd !== 32'h01020304 || lc !== 5) begin
      bad++;
      $display("[TB] FAIL aborted_write_discarded: got %h stall=%0d want 01020304 stall=5", rd, lc);
    end
  endtask

`ifdef AHB_SRAM_SLAVE_ERR_EN
  task automatic test_config();
    logic [31:0] rd;
    int          lc;
    logic [1:0]  rs;
    applyStimulus(0, 32'h0, 1'b1, 3'b010, 32'h11111111, rd, lc, rs);
    applyStimulus(0, 32'h2, 1'b1, 3'b010, 32'h99999999, rd, lc, rs);
    total++;
    if (rs !== 2'b01 || lc !== 1) begin
      bad++;
      $display("[TB] FAIL misaligned_error: got resp=%b stall=%0d want 01/1", rs, lc);
    end
    total++;
    if (hresp[0] !== 2'b00 || hreadyout[0] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL error_recovery: got resp=%b ready=%b want 00/1", hresp[0], hreadyout[0]);
    end
    applyStimulus(0, 32'h0, 1'b0, 3'b010, 32'h0, rd, lc, rs);
    total++;
    if (rd !== 32'h11111111) begin
      bad++;
      $display("[TB] FAIL error_no_write: got %h want 11111111", rd);
    end
    applyStimulus(0, 32'h1000, 1'b0, 3'b010, 32'h0, rd, lc, rs);
    total++;
    if (rs !== 2'b01 || lc !== 1 || rd !== 32'h0) begin
      bad++;
      $display("[TB] FAIL range_error: got resp=%b stall=%0d data=%h want 01/1/0", rs, lc, rd);
    end
  endtask
`else
  task automatic test_config();
    logic [31:0] rd;
    int          lc;
    logic [1:0]  rs;
    applyStimulus(0, 32'h2, 1'b1, 3'b010, 32'h99999999, rd, lc, rs);
    total++;
    if (rs !== 2'b00 || lc !== 0) begin
      bad++;
      $display("[TB] FAIL misaligned_okay: got resp=%b stall=%0d want 00/0", rs, lc);
    end
    applyStimulus(0, 32'h0, 1'b0, 3'b010, 32'h0, rd, lc, rs);
    total++;
    if (rd !== 32'h99999999) begin
      bad++;
      $display("[TB] FAIL misaligned_truncate: got %h want 99999999", rd);
    end
    applyStimulus(0, 32'h1050, 1'b1, 3'b010, 32'h00000077, rd, lc, rs);
    applyStimulus(0, 32'h50, 1'b0, 3'b010, 32'h0, rd, lc, rs);
    total++;
    if (rd !== 32'h77) begin
      bad++;
      $display("[TB] FAIL address_alias: got %h want 00000077", rd);
    end
  endtask
`endif

  initial begin
    idleBus();
    hwdata = 32'h0;
    hreset = 1'b1;
    @(negedge hclk);
    test_reset();
    test_single_rw();
    test_byte_lanes();
    test_back_to_back();
    test_idle_busy();
    test_wait_states();
    test_reset_mid_wait();
    test_config();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL be the width of haddr.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL be the width of hwdata and hrdata; only 32 is supported.
REQ-003 Parameter MEM_DEPTH, default 1024, SHALL be the number of 32-bit words of storage and SHALL be a power of 2.
REQ-004 Parameter WAIT_STATES, default 0, range 0..15, SHALL be the number of hreadyout-low cycles inserted in every active data phase.
REQ-005 Port list, clock and reset first:
- hclk  in  1  clock; all logic is on its rising edge
- hreset  in  1  reset; synchronous, active-high
- hselx  in  1  slave select from the interconnect
- haddr  in  ADDR_WIDTH  byte address
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- hwrite  in  1  1=write
- hsize  in  3  000=byte, 001=half, 010=word
- hburst  in  3  burst type; ignored functionally
- hprot  in  4  protection; ignored functionally
- hmastlock  in  1  locked transfer; ignored functionally
- hready  in  1  bus-wide ready (hreadyin)
- hwdata  in  32  write data, valid in the data phase
- hreadyout  out  1  slave ready
- hresp  out  2  OKAY=00, ERROR=01
- hrdata  out  32  read data

Function
REQ-006 An address phase SHALL be accepted on a rising edge when hselx=1, hready=1 and htrans is NONSEQ or SEQ; haddr, hwrite and hsize SHALL be registered into the data-phase register.
REQ-007 IDLE or BUSY transfers, and any cycle with hselx=0, SHALL produce no data phase; the next cycle SHALL return hreadyout=1 and hresp=OKAY.
REQ-008 FSM states:
- ST_IDLE
- ST_WAIT: counts WAIT_STATES cycles with hreadyout=0
- ST_ERR1: hresp=ERROR, hreadyout=0
- ST_ERR2: hresp=ERROR, hreadyout=1
REQ-009 Transitions for an accepted transfer:
- valid transfer, WAIT_STATES>0 -> ST_WAIT
- valid transfer, WAIT_STATES=0 -> data phase completes in the next cycle
- erroneous transfer -> ST_ERR1, then ST_ERR2, then ST_IDLE or next phase
REQ-010 In ST_WAIT the wait counter SHALL decrement each cycle; the data phase SHALL complete (hreadyout=1, hresp=OKAY) in the cycle after the counter reaches 0, for a total data-phase latency of WAIT_STATES+1 cycles.
REQ-011 A write SHALL update storage on the completing edge of the data phase; only byte lanes selected by hsize and haddr[1:0] (little-endian) SHALL change.
REQ-012 For a read, hrdata SHALL present the full 32-bit word at word index haddr[log2(MEM_DEPTH)+1:2] in the completing cycle; it is 0 in all other cycles.
REQ-013 A read address phase overlapping the data phase of a write to the same word SHALL return the newly written data.
REQ-014 While hreadyout=0, new address phases SHALL NOT be accepted; the interconnect holds them stable.
REQ-015 An address phase presented during the completing cycle of a previous data phase SHALL be accepted (back-to-back pipelining, zero bubble).
REQ-016 Address bits at or above log2(MEM_DEPTH)+2 SHALL be ignored for indexing when error support is compiled out (wrap-around aliasing).

Reset
REQ-017 While hreset=1 at a rising edge:
- FSM -> ST_IDLE, wait counter -> 0, data-phase register invalid
- hreadyout=1, hresp=OKAY, hrdata=0
- storage contents unchanged
REQ-018 Reset asserted mid-data-phase or mid-error SHALL abort the transfer; any pending write SHALL be discarded.

Configuration
REQ-019 Macro AHB_SRAM_SLAVE_ERR_EN, when defined, SHALL flag two error cases, each returning the two-cycle ERROR response with no write performed:
- address beyond MEM_DEPTH*4
- misaligned access (half with haddr[0]=1, word with haddr[1:0]!=0, hsize>010)
REQ-020 With AHB_SRAM_SLAVE_ERR_EN undefined, ST_ERR1 and ST_ERR2 SHALL not exist, hresp SHALL be constant OKAY, and misaligned addresses SHALL have low bits truncated.

Structure
REQ-021 Shared package AhbGlobalPackage SHALL hold the htrans encodings, hsize encodings, hresp encodings and the FSM state enum type.
REQ-022 Storage SHALL be a sub-module ahb_sram_byte_mem: single port, 4 byte-enables, write on clock, asynchronous read.

Verification
REQ-023 Reset, then single word write 0xDEADBEEF to 0x10, then read 0x10 with WAIT_STATES=0 -> hrdata=0xDEADBEEF one cycle after the read address phase; hresp=00.
REQ-024 WAIT_STATES=3, read 0x20 -> hreadyout low exactly 3 cycles, then high with data; the next address phase is held until then.
REQ-025 Byte write 0xAA to 0x13 over word 0x11223344 -> read 0x10 returns 0xAA223344.
REQ-026 Back-to-back write 0x5 to 0x40 then read 0x40 (NONSEQ every cycle) -> read returns 0x5, no bubble.
REQ-027 With AHB_SRAM_SLAVE_ERR_EN defined, word write to 0x2 -> hresp=01 with hreadyout 0 then 1; storage unchanged on read-back.
REQ-028 hreset asserted during WAIT_STATES=5 write -> outputs at reset values next cycle; the word keeps its old value.
